// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush scheduler for the 5-stage pipeline: load-use, taken branch, multi-cycle MDU hold, halt drain.
// Latency: control outputs are combinational from state and inputs; counters update on the closing edge.
// Backpressure: stalls PC/IFID and freezes EX while an MDU op or drain is in progress.
module pipe_hazard_ctrl #(
    parameter int MDU_CYCLES   = 8,
    parameter int DRAIN_CYCLES = 3,
    parameter int RA_W         = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [RA_W-1:0] ifid_rs,
    input  logic [RA_W-1:0] ifid_rt,
    input  logic            ifid_uses_rt,
    input  logic [RA_W-1:0] idex_rd,
    input  logic            idex_memread,
    input  logic            ex_branch_taken,
    input  logic            ex_mdu_op,
    input  logic            halt_req,
    output logic            pc_write,
    output logic            ifid_write,
    output logic            ifid_flush,
    output logic            idex_flush,
    output logic            ex_hold,
    output logic            mdu_done,
    output logic            halted,
    output logic [15:0]     stall_cnt,
    output logic [15:0]     flush_cnt
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MDU_BUSY = 2'd1,
        HALT     = 2'd2
    } state_t;

    localparam logic [2:0] MDU_LOAD  = 3'(MDU_CYCLES - 2);
    localparam logic [2:0] DRAIN_MAX = 3'(DRAIN_CYCLES);

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        stall_inc, flush_inc;
    logic        luh;

    assign luh = idex_memread &
                 ((idex_rd == ifid_rs) | (ifid_uses_rt & (idex_rd == ifid_rt)));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= RUN;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Outputs are gated by reset so the pipeline sees idle controls the moment reset asserts.
    always_comb begin
        pc_write   = 1'b1;
        ifid_write = 1'b1;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        ex_hold    = 1'b0;
        mdu_done   = 1'b0;
        halted     = 1'b0;
        stall_inc  = 1'b0;
        flush_inc  = 1'b0;
        state_d    = state_q;
        cnt_d      = cnt_q;
        if (reset) begin
            case (state_q)
                RUN: begin
                    if (ex_branch_taken) begin
                        ifid_flush = 1'b1;
                        idex_flush = 1'b1;
                        flush_inc  = 1'b1;
                    end else if (ex_mdu_op) begin
                        ex_hold    = 1'b1;
                        pc_write   = 1'b0;
                        ifid_write = 1'b0;
                        stall_inc  = 1'b1;
                        state_d    = MDU_BUSY;
                        cnt_d      = MDU_LOAD;
                    end else if (halt_req) begin
                        pc_write   = 1'b0;
                        ifid_write = 1'b0;
                        idex_flush = 1'b1;
                        state_d    = HALT;
                        cnt_d      = 3'd1;
                    end else if (luh) begin
                        pc_write   = 1'b0;
                        ifid_write = 1'b0;
                        idex_flush = 1'b1;
                        stall_inc  = 1'b1;
                    end
                end
                MDU_BUSY: begin
                    if (cnt_q != 3'd0) begin
                        ex_hold    = 1'b1;
                        pc_write   = 1'b0;
                        ifid_write = 1'b0;
                        stall_inc  = 1'b1;
                        cnt_d      = cnt_q - 3'd1;
                    end else begin
                        mdu_done   = 1'b1;
                        state_d    = RUN;
                    end
                end
                HALT: begin
                    if (!halt_req) begin
                        state_d = RUN;
                        cnt_d   = 3'd0;
                    end else begin
                        pc_write   = 1'b0;
                        ifid_write = 1'b0;
                        idex_flush = 1'b1;
                        halted     = (cnt_q == DRAIN_MAX);
                        if (cnt_q != DRAIN_MAX) begin
                            cnt_d = cnt_q + 3'd1;
                        end
                    end
                end
                default: begin
                    state_d = RUN;
                    cnt_d   = 3'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt <= 16'd0;
            flush_cnt <= 16'd0;
        end else begin
            if (stall_inc && (stall_cnt != 16'hFFFF)) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
            if (flush_inc && (flush_cnt != 16'hFFFF)) begin
                flush_cnt <= flush_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Randomized + directed bench for pipe_hazard_ctrl against a cycle-level behavioural model.
module tb_pipe_hazard_ctrl;

    localparam int MDU   = 8;
    localparam int DRAIN = 3;
    localparam int M_RUN  = 0;
    localparam int M_MDU  = 1;
    localparam int M_HALT = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  ifid_rs, ifid_rt, idex_rd;
    logic        ifid_uses_rt, idex_memread, ex_branch_taken, ex_mdu_op, halt_req;
    logic        pc_write, ifid_write, ifid_flush, idex_flush, ex_hold, mdu_done, halted;
    logic [15:0] stall_cnt, flush_cnt;

    int n_total = 0;
    int n_bad   = 0;

    // model state: mode, cycles the MDU op has spent in EX, bubbles injected so far
    int m_mode  = M_RUN;
    int m_age   = 0;
    int m_bub   = 0;
    int m_stall = 0;
    int m_flush = 0;

    pipe_hazard_ctrl #(.MDU_CYCLES(MDU), .DRAIN_CYCLES(DRAIN), .RA_W(4)) dut (
        .clk(clk), .reset(reset),
        .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .ifid_uses_rt(ifid_uses_rt),
        .idex_rd(idex_rd), .idex_memread(idex_memread),
        .ex_branch_taken(ex_branch_taken), .ex_mdu_op(ex_mdu_op), .halt_req(halt_req),
        .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
        .idex_flush(idex_flush), .ex_hold(ex_hold), .mdu_done(mdu_done), .halted(halted),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: drive at negedge, check just after, commit model for the coming posedge.
    task automatic step(input logic rst, input logic br, input logic mdu, input logic hreq,
                        input logic mr, input logic ut,
                        input logic [3:0] rs, input logic [3:0] rt, input logic [3:0] rd);
        logic [6:0] e;
        logic       luh;
        int n_mode, n_age, n_bub, n_stall, n_flush;
        @(negedge clk);
        reset = rst; ex_branch_taken = br; ex_mdu_op = mdu; halt_req = hreq;
        idex_memread = mr; ifid_uses_rt = ut; ifid_rs = rs; ifid_rt = rt; idex_rd = rd;
        #1;
        luh = mr && ((rd == rs) || (ut && (rd == rt)));
        if (!rst) begin
            m_mode = M_RUN; m_age = 0; m_bub = 0; m_stall = 0; m_flush = 0;
        end
        n_mode = m_mode; n_age = m_age; n_bub = m_bub; n_stall = m_stall; n_flush = m_flush;
        // e = {pc_write, ifid_write, ifid_flush, idex_flush, ex_hold, mdu_done, halted}
        e = 7'b1100000;
        if (rst) begin
            if (m_mode == M_RUN) begin
                if (br) begin
                    e = 7'b1111000; n_flush = m_flush + 1;
                end else if (mdu) begin
                    e = 7'b0000100; n_mode = M_MDU; n_age = 1; n_stall = m_stall + 1;
                end else if (hreq) begin
                    e = 7'b0001000; n_mode = M_HALT; n_bub = 1;
                end else if (luh) begin
                    e = 7'b0001000; n_stall = m_stall + 1;
                end
            end else if (m_mode == M_MDU) begin
                if (m_age < MDU - 1) begin
                    e = 7'b0000100; n_age = m_age + 1; n_stall = m_stall + 1;
                end else begin
                    e = 7'b1100010; n_mode = M_RUN;
                end
            end else begin
                if (!hreq) begin
                    n_mode = M_RUN;
                end else begin
                    e = {6'b000100, (m_bub >= DRAIN)};
                    n_bub = m_bub + 1;
                end
            end
        end
        chk("ctrl", {25'd0, pc_write, ifid_write, ifid_flush, idex_flush, ex_hold, mdu_done, halted},
            {25'd0, e});
        chk("stall_cnt", {16'd0, stall_cnt}, m_stall);
        chk("flush_cnt", {16'd0, flush_cnt}, m_flush);
        m_mode = n_mode; m_age = n_age; m_bub = n_bub;
        m_stall = (n_stall > 65535) ? 65535 : n_stall;
        m_flush = (n_flush > 65535) ? 65535 : n_flush;
    endtask

    task automatic idle();
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1, 4'd2, 4'd0);
    endtask

    task automatic do_reset();
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1, 4'd2, 4'd0);
    endtask

    initial begin
        reset = 1'b0; ex_branch_taken = 1'b0; ex_mdu_op = 1'b0; halt_req = 1'b0;
        idex_memread = 1'b0; ifid_uses_rt = 1'b0; ifid_rs = '0; ifid_rt = '0; idex_rd = '0;

        // reset state and idle run
        do_reset();
        do_reset();
        for (int i = 0; i < 10; i++) idle();
        chk("t1_stall", {16'd0, stall_cnt}, 32'd0);

        // load-use via rs, then rt match without uses_rt
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd3, 4'd0, 4'd3);
        idle();
        chk("t2_luh_stall", {16'd0, stall_cnt}, 32'd1);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd5, 4'd3, 4'd3);
        idle();
        chk("t2_nouse_rt", {16'd0, stall_cnt}, 32'd1);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'd5, 4'd3, 4'd3);
        idle();
        chk("t2_rt_stall", {16'd0, stall_cnt}, 32'd2);

        // single MDU op, then back-to-back ops
        do_reset();
        for (int i = 0; i < MDU; i++) step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd1, 4'd2, 4'd0);
        idle();
        chk("t3_mdu_stall", {16'd0, stall_cnt}, 32'd7);
        for (int i = 0; i < 2 * MDU; i++) step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'd3, 4'd2, 4'd3);
        idle();
        chk("t3_b2b_stall", {16'd0, stall_cnt}, 32'd21);

        // branch together with load-use
        do_reset();
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd3, 4'd0, 4'd3);
        idle();
        chk("t4_flush", {16'd0, flush_cnt}, 32'd1);
        chk("t4_stall", {16'd0, stall_cnt}, 32'd0);

        // halt held, drop, then drop mid-drain
        do_reset();
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd1, 4'd2, 4'd0);
        idle();
        idle();
        for (int i = 0; i < 2; i++) step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd1, 4'd2, 4'd0);
        idle();
        idle();

        // reset in the middle of an MDU sequence
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd1, 4'd2, 4'd0);
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'd3, 4'd2, 4'd3);
        idle();

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            logic br, md;
            br = ($urandom_range(0, 9) == 0);
            md = ($urandom_range(0, 19) == 0);
            step(($urandom_range(0, 199) != 0), br, md, ($urandom_range(0, 3) != 0 && m_mode == M_HALT) ||
                 ($urandom_range(0, 24) == 0),
                 1'($urandom), 1'($urandom),
                 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)));
        end

        // stall counter saturation
        do_reset();
        for (int i = 0; i < 65540; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd3, 4'd0, 4'd3);
        idle();
        chk("t6_sat", {16'd0, stall_cnt}, 32'h0000FFFF);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
